ctrl_pipe_decoder: RTL
======================

Name: ctrl_pipe_decoder

Overview:
- Next-generation MIPS main control unit with a registered ID/EX control bundle: one cycle of latency from decode to the EX-stage control outputs.
- Decodes opcode and funct into a parametrised ALU-op code with a distinct code per operation (ORI, XORI, SLTI and LUI no longer share codes).
- Detects load-use hazards, inserts bubbles and drives the IF/ID stall.
- Handles flush from branch resolution.
- Runs a HALT drain FSM that the debug unit uses to freeze the pipeline.

Parameters:
- NB_OP, 6, opcode and funct width.
- NB_REG, 5, register-specifier width.
- NB_ALUOP, 4, ALU-op code width; must be >= 4.
- LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard; must be >= 1.
- DRAIN_CYCLES, 3, cycles to wait after HALT issue before reporting halted; must be >= 1.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  ID-stage instruction valid.
- i_opcode  in  NB_OP  instr[31:26].
- i_funct  in  NB_OP  instr[5:0].
- i_rs  in  NB_REG  instr[25:21].
- i_rt  in  NB_REG  instr[20:16].
- i_ex_memRead  in  1  instruction in EX is a load.
- i_ex_rt  in  NB_REG  destination of the load in EX.
- i_flush  in  1  branch/jump taken; kill the ID instruction.
- i_resume  in  1  debug: leave HALTED.
- i_step  in  1  debug single-step (see Optional Feature).
- o_valid, o_jump, o_jal, o_jump_reg, o_branch, o_bne, o_aluSrc, o_regDst, o_mem2Reg, o_regWrite, o_memRead, o_memWrite, o_sign_flag, o_immediate  out  1 each  registered EX controls.
- o_aluOp  out  NB_ALUOP  registered ALU-op code.
- o_width  out  2  registered access width: 11 word, 01 half, 00 byte.
- o_illegal  out  1  registered; one-cycle pulse on an undefined opcode.
- o_stall  out  1  combinational; hold PC and IF/ID.
- o_halted  out  1  registered; 1 while in HALTED.

Behaviour:
- Reset (synchronous, i_rst=1 at a clk edge):
  - All registered outputs go to 0, except o_width=2'b11.
  - FSM enters RUN and the stall counter goes to 0.
  - o_stall is 0 while i_rst is asserted.
- Bubble definition: every control output 0, o_valid=0, o_width=11.
- Decoded instruction set: R, LW/LH/LB/LHU/LBU/LWU, SW/SH/SB, BEQ, BNE, ADDI, SLTI, ORI, XORI, LUI, J, JAL and HALT (6'b111111).
- Field values per instruction class:
  - Loads set sign_flag=1 for the unsigned variants.
  - R-type emits ALU_FUNCT. funct 001000 (JR) gives jump_reg=1 and regWrite=0. funct 001001 (JALR) gives jump_reg=1 and regWrite=1.
  - JAL gives jump=1, jal=1, regWrite=1.
  - BNE gives branch=1 and bne=1.
- Undefined opcode: issue a bubble and pulse o_illegal for one cycle.
- Priority within each cycle: i_rst > i_flush > stall/FSM > normal decode.
- i_flush=1: the next registered bundle is a bubble, the stall counter clears, and o_stall=0 (except in DRAIN or HALTED, where o_stall stays 1).
- Load-use hazard condition, evaluated only in RUN with the counter at 0 and i_valid=1: i_ex_memRead && i_ex_rt!=0 && (i_ex_rt==i_rs || (i_ex_rt==i_rt && the instruction reads rt)).
  - Instructions that read rt: R-type, stores, BEQ, BNE.
  - Detection cycle: o_stall=1, issue a bubble, load the counter with LOAD_USE_STALLS-1.
  - While the counter is non-zero: o_stall=1, issue a bubble, decrement the counter.
  - Once the counter reaches 0, the held instruction is decoded normally.
- i_valid=0: issue a bubble and do not stall.
- FSM:
  - RUN: a valid HALT with no hazard and no flush issues a bubble with o_stall=0, which consumes the HALT. Load drain count = DRAIN_CYCLES and go to DRAIN.
  - DRAIN: o_stall=1, issue bubbles, decrement the count. At 0, go to HALTED. i_resume and i_flush have no state effect.
  - HALTED: o_halted=1, o_stall=1, issue bubbles. i_resume=1 goes to RUN on the next cycle.
- Reset in any state returns to RUN.

Optional Feature:
- Macro CTRL_DEBUG_STEP_EN.
- With the macro defined, i_step=1 in HALTED (i_resume=0) does the following:
  - Releases one cycle with o_stall=0 and the ID instruction decoded normally.
  - If a hazard is detected in that cycle, the hazard rules apply and the step retries after the stall.
  - The FSM then reloads the drain count and goes through DRAIN back to HALTED.
  - If i_step and i_resume are both 1, i_resume wins.
- Without the macro: i_step is ignored (the port remains present) and the STEP state does not exist.

Decomposition:
- Package ctrl_pkg holds the following.
  - Opcode localparams: R, LW, SW, BEQ, BNE, ADDI, SLTI, ORI, XORI, LUI, J, JAL, LB, LH, LBU, LHU, LWU, SB, SH, HALT.
  - Funct codes: JR, JALR.
  - ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, LUI 11, FUNCT 15.
  - FSM state encodings: RUN, DRAIN, HALTED, STEP.
- One sub-module, ctrl_decode_comb: a pure combinational opcode/funct to control-word decoder, including the illegal flag.
- The top level holds the hazard logic, the counters, the FSM and the ID/EX register.

Test Plan:
- ORI then XORI, both valid, no hazard -> one cycle later o_aluOp=3 then 4; both have o_immediate=1, o_regWrite=1, o_valid=1.
- LOAD_USE_STALLS=2; EX has memRead=1 and rt=5; ID holds ADD with rs=5 -> o_stall=1 for 2 cycles with 2 bubbles, then an R-type bundle with o_aluOp=15. Repeat with i_ex_rt=0 -> no stall.
- Load-use stall active and i_flush=1 in the same cycle -> bubble, counter cleared, o_stall=0 on the next cycle.
- HALT issued with DRAIN_CYCLES=3 -> o_stall=0 in the issue cycle, then 1; o_halted=1 on the 4th cycle after issue. i_resume -> RUN and the next instruction is decoded.
- Opcode 6'b110011 -> bubble and o_illegal pulses high for exactly one cycle. Assert i_rst during DRAIN -> RUN on the next cycle, all outputs at reset values, o_width=11.
- With CTRL_DEBUG_STEP_EN: in HALTED with ID=ADDI, pulse i_step -> one bundle with o_valid=1 and aluOp=0, followed by DRAIN_CYCLES bubbles, then back to HALTED.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the MIPS main control unit.
//   - Opcode and funct encodings of the decoded instruction set.
//   - ALU-op codes: one distinct code per operation.
//   - FSM state encodings for the HALT drain controller.
//   - ctrl_word_t: the EX-stage control bundle.
//   - bubble_word(): the all-quiet bundle, which keeps word width.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_LWU  = 6'b100111;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_LUI   = 4'd11;
  localparam logic [3:0] ALU_FUNCT = 4'd15;

  localparam logic [1:0] W_WORD = 2'b11;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b00;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  typedef struct packed {
    logic       jump;
    logic       jal;
    logic       jump_reg;
    logic       branch;
    logic       bne;
    logic       alu_src;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       sign_flag;
    logic       immediate;
    logic [3:0] alu_op;
    logic [1:0] width;
  } ctrl_word_t;

  function automatic ctrl_word_t bubble_word();
    bubble_word       = '0;
    bubble_word.width = W_WORD;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational opcode/funct -> control-word decoder.
// Ports:
//   i_opcode    opcode field instr[31:26]
//   i_funct     funct field instr[5:0]
//   o_ctrl      decoded control word (a bubble for HALT and undefined opcodes)
//   o_reads_rt  instruction sources rt (R-type, stores, BEQ, BNE)
//   o_is_halt   opcode is HALT
//   o_illegal   opcode is undefined
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int NB_OP = 6
) (
  input  logic [NB_OP-1:0] i_opcode,
  input  logic [NB_OP-1:0] i_funct,
  output ctrl_word_t       o_ctrl,
  output logic             o_reads_rt,
  output logic             o_is_halt,
  output logic             o_illegal
);

  always_comb begin
    o_ctrl     = bubble_word();
    o_reads_rt = 1'b0;
    o_is_halt  = 1'b0;
    o_illegal  = 1'b0;
    case (i_opcode)
      OP_R: begin
        o_ctrl.alu_op  = ALU_FUNCT;
        o_ctrl.reg_dst = 1'b1;
        o_reads_rt     = 1'b1;
        if (i_funct == FN_JR) begin
          o_ctrl.jump_reg = 1'b1;
        end else if (i_funct == FN_JALR) begin
          o_ctrl.jump_reg  = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end else begin
          o_ctrl.reg_write = 1'b1;
        end
      end
      OP_LW, OP_LH, OP_LB, OP_LWU, OP_LHU, OP_LBU: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem2reg   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        // Unsigned loads zero-extend the loaded value.
        o_ctrl.sign_flag = (i_opcode == OP_LWU) || (i_opcode == OP_LHU) ||
                           (i_opcode == OP_LBU);
        if ((i_opcode == OP_LH) || (i_opcode == OP_LHU))
          o_ctrl.width = W_HALF;
        else if ((i_opcode == OP_LB) || (i_opcode == OP_LBU))
          o_ctrl.width = W_BYTE;
      end
      OP_SW, OP_SH, OP_SB: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_reads_rt       = 1'b1;
        if (i_opcode == OP_SH)
          o_ctrl.width = W_HALF;
        else if (i_opcode == OP_SB)
          o_ctrl.width = W_BYTE;
      end
      OP_BEQ, OP_BNE: begin
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.branch = 1'b1;
        o_ctrl.bne    = (i_opcode == OP_BNE);
        o_reads_rt    = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ORI, OP_XORI, OP_LUI: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.immediate = 1'b1;
        case (i_opcode)
          OP_SLTI: o_ctrl.alu_op = ALU_SLT;
          OP_ORI:  o_ctrl.alu_op = ALU_OR;
          OP_XORI: o_ctrl.alu_op = ALU_XOR;
          OP_LUI:  o_ctrl.alu_op = ALU_LUI;
          default: o_ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_J: begin
        o_ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        o_ctrl.jump      = 1'b1;
        o_ctrl.jal       = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_HALT: begin
        o_is_halt = 1'b1;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// ctrl_pipe_decoder: MIPS main control unit with a registered ID/EX bundle.
// Decodes in ID and registers the EX controls one cycle later. It also
// handles load-use stalls, branch flushes, and the debug HALT drain FSM.
// Optional build macro CTRL_DEBUG_STEP_EN enables single-step from HALTED
// through i_step. Without that macro, i_step is ignored.
// Ports:
//   clk, i_rst                 clock, synchronous active-high reset
//   i_valid, i_opcode, i_funct ID-stage instruction
//   i_rs, i_rt                 ID-stage source registers
//   i_ex_memRead, i_ex_rt      load currently in EX and its destination
//   i_flush                    kill the ID instruction
//   i_resume, i_step           debug controls
//   o_* control flags, o_aluOp, o_width, o_illegal, o_halted  registered
//   o_stall                    combinational PC / IF-ID hold
module ctrl_pipe_decoder
  import ctrl_pkg::*;
#(
  parameter int NB_OP           = 6,
  parameter int NB_REG          = 5,
  parameter int NB_ALUOP        = 4,
  parameter int LOAD_USE_STALLS = 1,
  parameter int DRAIN_CYCLES    = 3
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [NB_OP-1:0]    i_opcode,
  input  logic [NB_OP-1:0]    i_funct,
  input  logic [NB_REG-1:0]   i_rs,
  input  logic [NB_REG-1:0]   i_rt,
  input  logic                i_ex_memRead,
  input  logic [NB_REG-1:0]   i_ex_rt,
  input  logic                i_flush,
  input  logic                i_resume,
  input  logic                i_step,
  output logic                o_valid,
  output logic                o_jump,
  output logic                o_jal,
  output logic                o_jump_reg,
  output logic                o_branch,
  output logic                o_bne,
  output logic                o_aluSrc,
  output logic                o_regDst,
  output logic                o_mem2Reg,
  output logic                o_regWrite,
  output logic                o_memRead,
  output logic                o_memWrite,
  output logic                o_sign_flag,
  output logic                o_immediate,
  output logic [NB_ALUOP-1:0] o_aluOp,
  output logic [1:0]          o_width,
  output logic                o_illegal,
  output logic                o_stall,
  output logic                o_halted
);

  localparam int CNT_W   = (LOAD_USE_STALLS > 1) ? $clog2(LOAD_USE_STALLS) : 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(LOAD_USE_STALLS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  ctrl_word_t dec_ctrl;
  logic       dec_reads_rt;
  logic       dec_is_halt;
  logic       dec_illegal;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               stall;
  logic               issue;
  logic               hazard;
  logic               in_step;

  ctrl_word_t ctrl_p1;
  logic       vld_p1;
  logic       illegal_p1;
  logic       halted_p1;

  ctrl_decode_comb #(
    .NB_OP (NB_OP)
  ) u_decode (
    .i_opcode   (i_opcode),
    .i_funct    (i_funct),
    .o_ctrl     (dec_ctrl),
    .o_reads_rt (dec_reads_rt),
    .o_is_halt  (dec_is_halt),
    .o_illegal  (dec_illegal)
  );

`ifdef CTRL_DEBUG_STEP_EN
  assign in_step = (state_q == ST_STEP);
`else
  logic unused_step;
  assign unused_step = i_step;
  assign in_step     = 1'b0;
`endif

  // Register 0 is never a real load destination, so it cannot cause a hazard.
  assign hazard = i_valid && i_ex_memRead && (i_ex_rt != '0) &&
                  ((i_ex_rt == i_rs) || ((i_ex_rt == i_rt) && dec_reads_rt));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    stall   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      // Flush does not disturb the drain or halted state; the pipe stays frozen.
      ST_DRAIN: begin
        stall   = 1'b1;
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q <= DRAIN_W'(1))
          state_d = ST_HALTED;
      end
      ST_HALTED: begin
        stall = 1'b1;
        if (i_resume)
          state_d = ST_RUN;
`ifdef CTRL_DEBUG_STEP_EN
        else if (i_step)
          state_d = ST_STEP;
`endif
      end
      default: begin
        // RUN, and STEP when that state is built.
        if (!i_flush) begin
          if (cnt_q != '0) begin
            stall = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
          end else if (hazard) begin
            stall = 1'b1;
            cnt_d = CNT_LOAD;
          end else begin
            issue = i_valid && !dec_is_halt;
            // A HALT is consumed as a bubble. A released step cycle then
            // re-freezes through the drain.
            if ((i_valid && dec_is_halt) || in_step) begin
              drain_d = DRAIN_LOAD;
              state_d = ST_DRAIN;
            end
          end
        end
      end
    endcase
    if (i_flush)
      cnt_d = '0;
  end

  assign o_stall = stall && !i_rst;

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      drain_q    <= '0;
      ctrl_p1    <= bubble_word();
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      halted_p1  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      ctrl_p1    <= (issue && !dec_illegal) ? dec_ctrl : bubble_word();
      vld_p1     <= issue && !dec_illegal;
      illegal_p1 <= issue && dec_illegal;
      halted_p1  <= (state_d == ST_HALTED);
    end
  end

  assign o_valid     = vld_p1;
  assign o_jump      = ctrl_p1.jump;
  assign o_jal       = ctrl_p1.jal;
  assign o_jump_reg  = ctrl_p1.jump_reg;
  assign o_branch    = ctrl_p1.branch;
  assign o_bne       = ctrl_p1.bne;
  assign o_aluSrc    = ctrl_p1.alu_src;
  assign o_regDst    = ctrl_p1.reg_dst;
  assign o_mem2Reg   = ctrl_p1.mem2reg;
  assign o_regWrite  = ctrl_p1.reg_write;
  assign o_memRead   = ctrl_p1.mem_read;
  assign o_memWrite  = ctrl_p1.mem_write;
  assign o_sign_flag = ctrl_p1.sign_flag;
  assign o_immediate = ctrl_p1.immediate;
  assign o_aluOp     = NB_ALUOP'(ctrl_p1.alu_op);
  assign o_width     = ctrl_p1.width;
  assign o_illegal   = illegal_p1;
  assign o_halted    = halted_p1;

endmodule
